// File: rtl/seq_pkg.sv
// Constants and encodings shared by the 111_0010 sequence detector and frame_capture.
package seq_pkg;

  localparam int unsigned DEF_PAYLOAD_W = 8;
  localparam int unsigned SYNC_W        = 7;
  localparam logic [SYNC_W-1:0] SYNC_PATTERN = 7'b111_0010;

  typedef enum logic {
    FC_IDLE  = 1'b0,
    FC_SHIFT = 1'b1
  } fc_state_e;

endpackage

// File: rtl/frame_hold_reg.sv
// Output holding register: presents completed words on a valid/ready port,
// counts loaded frames and flags frames dropped because the register was busy.
module frame_hold_reg #(
  parameter int unsigned PAYLOAD_W = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [PAYLOAD_W-1:0] word,
  input  logic                 data_ready,
  input  logic                 ovr_clr,
  output logic [PAYLOAD_W-1:0] data_out,
  output logic                 data_valid,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic                 overrun
);

  logic accept;
  logic free;

  assign accept = data_valid && data_ready;
  assign free   = !data_valid || accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_cnt  <= '0;
      overrun    <= 1'b0;
    end else begin
      if (load && free) begin
        data_out   <= word;
        data_valid <= 1'b1;
        frame_cnt  <= frame_cnt + CNT_W'(1);
      end else if (accept) begin
        data_valid <= 1'b0;
      end
      // A drop on the same edge as a clear keeps the flag set.
      if (load && !free) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/frame_capture.sv
// Deserializes PAYLOAD_W bits (MSB first) following each sync hit and hands
// the completed word to frame_hold_reg.
module frame_capture
  import seq_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 x,
  input  logic                 sync_hit,
  output logic [PAYLOAD_W-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic                 overrun,
  input  logic                 ovr_clr
);

  localparam int unsigned BC_W = $clog2(PAYLOAD_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(PAYLOAD_W - 1);

  fc_state_e             state;
  logic [BC_W-1:0]       bit_cnt;
  logic [PAYLOAD_W-2:0]  shreg;
  logic [PAYLOAD_W-1:0]  word;
  logic                  load;

  assign word = {shreg, x};
  assign load = (state == FC_SHIFT) && (bit_cnt == LAST_BIT);

  // Capture FSM; sync_hit is only looked at while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FC_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        FC_IDLE: begin
          if (sync_hit) begin
            shreg   <= word[PAYLOAD_W-2:0];
            bit_cnt <= BC_W'(1);
            state   <= FC_SHIFT;
          end
        end
        FC_SHIFT: begin
          shreg <= word[PAYLOAD_W-2:0];
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            state   <= FC_IDLE;
          end else begin
            bit_cnt <= bit_cnt + BC_W'(1);
          end
        end
        default: state <= FC_IDLE;
      endcase
    end
  end

  frame_hold_reg #(
    .PAYLOAD_W (PAYLOAD_W),
    .CNT_W     (CNT_W)
  ) u_hold (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .word       (word),
    .data_ready (data_ready),
    .ovr_clr    (ovr_clr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_cnt  (frame_cnt),
    .overrun    (overrun)
  );

endmodule
